// File: rtl/irq_ctrl_pkg.sv
// ============================================================================
// Module   : irq_ctrl_pkg
// Purpose  : Shared constants for the J1 interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_ctrl_pkg;

    localparam int          NUM_IRQ     = 8;

    localparam logic [3:0]  IRQ_PENDING = 4'd0;
    localparam logic [3:0]  IRQ_ENABLE  = 4'd1;
    localparam logic [3:0]  IRQ_MODE    = 4'd2;
    localparam logic [3:0]  IRQ_SWTRIG  = 4'd3;
    localparam logic [3:0]  IRQ_ACTIVE  = 4'd4;

    localparam logic [15:0] IRQ_NONE    = 16'h8000;

endpackage

`default_nettype wire

// File: rtl/irq_edge.sv
// ============================================================================
// Module   : irq_edge
// Purpose  : Per-source sampler: optional two-flop synchroniser (IRQ_SYNC_EN),
//            previous-sample flop and rising-edge detect.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_edge (
    input  logic clk,
    input  logic i_src,
    output logic o_s,
    output logic o_rise
);

    // No reset on these flops: they keep sampling through reset so a source
    // held high across reset never looks like a fresh edge afterwards.
`ifdef IRQ_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
        r_sync1 <= i_src;
        r_sync2 <= r_sync1;
    end

    assign o_s = r_sync2;
`else
    assign o_s = i_src;
`endif

    logic r_prev;

    always_ff @(posedge clk) begin
        r_prev <= o_s;
    end

    assign o_rise = o_s & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/irq_ctrl.sv
// ============================================================================
// Module   : irq_ctrl
// Purpose  : Eight-source interrupt controller for the J1 int_rqst vector with
//            PENDING/ENABLE/MODE/SWTRIG/ACTIVE IO registers.
//            Define IRQ_SYNC_EN to add a two-flop synchroniser per source.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  irq_src,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    output logic [7:0]  int_rqst
);

    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_enable;
    logic [NUM_IRQ-1:0] r_mode;

    logic [NUM_IRQ-1:0] w_s;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_w1c;
    logic [NUM_IRQ-1:0] w_swtrig;
    logic [NUM_IRQ-1:0] w_pending_nxt;
    logic [15:0]        w_active;
    logic               w_hit;
    logic               w_wr;
    logic               w_unused_hi;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_src
            irq_edge u_edge (
                .clk    (clk),
                .i_src  (irq_src[gi]),
                .o_s    (w_s[gi]),
                .o_rise (w_rise[gi])
            );
        end
    endgenerate

    assign w_hit       = (io_addr[15:4] == BASE_ADDR[15:4]);
    assign w_wr        = io_wr & w_hit;
    assign w_w1c       = (w_wr && io_addr[3:0] == IRQ_PENDING) ? io_dout[7:0] : '0;
    assign w_swtrig    = (w_wr && io_addr[3:0] == IRQ_SWTRIG)  ? io_dout[7:0] : '0;
    assign w_unused_hi = &{1'b0, io_dout[15:8]};

    // Edge bits: set (rise or software trigger) wins over W1C.
    // Level bits simply track the sampled source.
    assign w_pending_nxt = (r_mode & ((r_pending & ~w_w1c) | w_rise | w_swtrig))
                         | (~r_mode & w_s);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            r_enable  <= '0;
            r_mode    <= '1;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_wr && io_addr[3:0] == IRQ_ENABLE) begin
                r_enable <= io_dout[7:0];
            end
            if (w_wr && io_addr[3:0] == IRQ_MODE) begin
                r_mode <= io_dout[7:0];
            end
        end
    end

    assign int_rqst = r_pending & r_enable;

    // Highest set request wins; later iterations overwrite lower indices.
    always_comb begin
        w_active = IRQ_NONE;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (int_rqst[i]) begin
                w_active = {13'b0, 3'(i)};
            end
        end
    end

    always_comb begin
        io_din = '0;
        if (io_rd && w_hit) begin
            case (io_addr[3:0])
                IRQ_PENDING: io_din = {8'h00, r_pending};
                IRQ_ENABLE:  io_din = {8'h00, r_enable};
                IRQ_MODE:    io_din = {8'h00, r_mode};
                IRQ_ACTIVE:  io_din = w_active;
                default:     io_din = '0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// ============================================================================
// Module   : tb_irq_ctrl
// Purpose  : Directed self-checking bench for irq_ctrl (either IRQ_SYNC_EN build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_ctrl;

`ifdef IRQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    localparam logic [15:0] BASE = 16'h0100;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq_src;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_addr;
    logic [15:0] io_dout;
    logic [15:0] io_din;
    logic [7:0]  int_rqst;

    int checks = 0;
    int errors = 0;

    irq_ctrl #(.BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .reset    (reset),
        .irq_src  (irq_src),
        .io_rd    (io_rd),
        .io_wr    (io_wr),
        .io_addr  (io_addr),
        .io_dout  (io_dout),
        .io_din   (io_din),
        .int_rqst (int_rqst)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic io_write(input logic [15:0] addr, input logic [15:0] data);
        io_addr = addr;
        io_dout = data;
        io_wr   = 1'b1;
        tick();
        io_wr   = 1'b0;
    endtask

    task automatic io_read(input logic [15:0] addr, output logic [15:0] data);
        io_addr = addr;
        io_rd   = 1'b1;
        #1;
        data    = io_din;
        io_rd   = 1'b0;
        #1;
    endtask

    task automatic read_check(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        logic [15:0] d;
        io_read(addr, d);
        check(tag, d, exp);
    endtask

    task automatic pulse(input logic [7:0] bits);
        irq_src = bits;
        tick();
        irq_src = 8'h00;
        repeat (LAT) tick();
    endtask

    initial begin
        logic [15:0] d;
        reset   = 1'b1;
        irq_src = 8'h00;
        io_rd   = 1'b0;
        io_wr   = 1'b0;
        io_addr = 16'h0000;
        io_dout = 16'h0000;
        repeat (4) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_din_idle", io_din, 16'h0000);
        check("rst_int_rqst", {8'h00, int_rqst}, 16'h0000);
        read_check("rst_pending", BASE + 0, 16'h0000);
        read_check("rst_enable",  BASE + 1, 16'h0000);
        read_check("rst_mode",    BASE + 2, 16'h00FF);
        read_check("rst_active",  BASE + 4, 16'h8000);

        // Single edge source, ENABLE=FF
        io_write(BASE + 1, 16'h00FF);
        pulse(8'h08);
        read_check("p3_pending", BASE + 0, 16'h0008);
        check("p3_int_rqst", {8'h00, int_rqst}, 16'h0008);
        read_check("p3_active", BASE + 4, 16'h0003);
        io_write(BASE + 0, 16'h0008);
        check("p3_w1c_int_rqst", {8'h00, int_rqst}, 16'h0000);

        // Priority and masking
        pulse(8'h42);
        io_write(BASE + 1, 16'h0042);
        read_check("pri_active_6", BASE + 4, 16'h0006);
        io_write(BASE + 0, 16'h0040);
        read_check("pri_active_1", BASE + 4, 16'h0001);
        io_write(BASE + 1, 16'h0000);
        read_check("pri_active_none", BASE + 4, 16'h8000);
        read_check("pri_pending_kept", BASE + 0, 16'h0002);
        io_write(BASE + 0, 16'h0002);

        // Level mode
        io_write(BASE + 2, 16'h0000);
        irq_src = 8'h01;
        tick();
        repeat (LAT) tick();
        read_check("lvl_pending_hi", BASE + 0, 16'h0001);
        io_write(BASE + 0, 16'h0001);
        read_check("lvl_w1c_noeffect", BASE + 0, 16'h0001);
        irq_src = 8'h00;
        tick();
        repeat (LAT) tick();
        read_check("lvl_pending_lo", BASE + 0, 16'h0000);

        // Level to edge switch holds the bit; no rise while source stays high
        irq_src = 8'h01;
        tick();
        repeat (LAT) tick();
        io_write(BASE + 2, 16'h00FF);
        repeat (2) tick();
        read_check("switch_hold", BASE + 0, 16'h0001);
        io_write(BASE + 0, 16'h0001);
        read_check("switch_edge_w1c", BASE + 0, 16'h0000);
        irq_src = 8'h00;
        repeat (LAT + 1) tick();

        // Set beats clear in the same cycle
        irq_src = 8'h04;
        repeat (LAT) tick();
        io_write(BASE + 0, 16'h0004);
        irq_src = 8'h00;
        read_check("set_beats_clr", BASE + 0, 16'h0004);
        io_write(BASE + 0, 16'h0004);

        // Software trigger and miscellaneous decode
        io_write(BASE + 3, 16'h0081);
        read_check("swtrig_pending", BASE + 0, 16'h0081);
        io_write(BASE + 1, 16'hFF0F);
        read_check("enable_upper_ignored", BASE + 1, 16'h000F);
        check("swtrig_int_rqst", {8'h00, int_rqst}, 16'h0001);
        read_check("swtrig_reads0", BASE + 3, 16'h0000);
        read_check("reg5_reads0", BASE + 5, 16'h0000);
        read_check("miss_reads0", 16'h0201, 16'h0000);

        // Simultaneous read and write: read sees the old value
        io_addr = BASE + 1;
        io_dout = 16'h0033;
        io_rd   = 1'b1;
        io_wr   = 1'b1;
        #1;
        check("rdwr_old", io_din, 16'h000F);
        tick();
        io_rd   = 1'b0;
        io_wr   = 1'b0;
        read_check("rdwr_new", BASE + 1, 16'h0033);
        io_write(BASE + 0, 16'h0081);

        // Mid-operation reset with a source held high across it
        pulse(8'h10);
        read_check("prerst_pending", BASE + 0, 16'h0010);
        irq_src = 8'hFF;
        reset   = 1'b1;
        tick();
        read_check("midrst_pending", BASE + 0, 16'h0000);
        read_check("midrst_enable",  BASE + 1, 16'h0000);
        read_check("midrst_mode",    BASE + 2, 16'h00FF);
        check("midrst_int_rqst", {8'h00, int_rqst}, 16'h0000);
        repeat (4) tick();
        reset = 1'b0;
        repeat (4) tick();
        read_check("held_src_no_rise", BASE + 0, 16'h0000);

        // Source-to-PENDING latency
        irq_src = 8'h00;
        repeat (LAT + 2) tick();
        io_write(BASE + 1, 16'h00FF);
        irq_src = 8'h20;
        check("lat_before_edge", {8'h00, int_rqst}, 16'h0000);
        for (int k = 0; k <= LAT; k++) begin
            tick();
            io_read(BASE + 0, d);
            check($sformatf("lat_edge%0d", k), d, (k == LAT) ? 16'h0020 : 16'h0000);
        end
        irq_src = 8'h00;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
